// File: rtl/axis_write_resp_pkg.sv
// Shared types and constants for the AXI write-response stage and its cfg front end.
package axis_write_resp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_CONFIG = 4'b0010,
      ST_ACTIVE = 4'b0100,
      ST_DONE   = 4'b1000
   } state_t;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;
   localparam logic [1:0] UNEXP_B      = 2'b11;

endpackage

// File: rtl/axis_write_resp_cfg_capture.sv
// Registers the cfg bus, matches the engine id word and picks the length word
// (second data word) out of a config frame.
module axis_cfg_capture
   import axis_write_resp_pkg::*;
#(
   parameter int unsigned CFG_ID     = 1,
   parameter int unsigned CFG_ADDR   = 23,
   parameter int unsigned CFG_DATA   = 24,
   parameter int unsigned CFG_AWIDTH = 5,
   parameter int unsigned CFG_DWIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CFG_AWIDTH-1:0] i_cfg_addr,
   input  logic [CFG_DWIDTH-1:0] i_cfg_data,
   input  logic                  i_cfg_valid,
   input  logic                  i_frame_en,
   output logic                  o_id_hit,
   output logic                  o_len_valid,
   output logic [CFG_DWIDTH-1:0] o_len
);

   logic [CFG_AWIDTH-1:0] r_cfg_addr;
   logic [CFG_DWIDTH-1:0] r_cfg_data;
   logic                  r_cfg_valid;
   logic                  r_word_seen;
   logic                  w_addressed;
   logic                  w_data_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_addr  <= '0;
         r_cfg_data  <= '0;
         r_cfg_valid <= 1'b0;
      end else begin
         r_cfg_addr  <= i_cfg_addr;
         r_cfg_data  <= i_cfg_data;
         r_cfg_valid <= i_cfg_valid;
      end
   end

   assign w_addressed = r_cfg_valid && (r_cfg_addr == CFG_AWIDTH'(CFG_ADDR));
   assign w_data_word = r_cfg_valid && (r_cfg_addr == CFG_AWIDTH'(CFG_DATA));

   // Word 0 (start address) only advances the count; word 1 carries the length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_seen <= 1'b0;
      end else if (!i_frame_en) begin
         r_word_seen <= 1'b0;
      end else if (w_data_word) begin
         r_word_seen <= 1'b1;
      end
   end

   assign o_id_hit    = w_addressed && (r_cfg_data == CFG_DWIDTH'(CFG_ID));
   assign o_len_valid = i_frame_en && w_data_word && r_word_seen;
   assign o_len       = r_cfg_data;

endmodule

// File: rtl/axis_write_resp.sv
// AXI write-response stage: counts issued AW bursts/beats, retires B responses,
// and reports completion (done/busy) and sticky response errors.
module axis_write_resp
   import axis_write_resp_pkg::*;
#(
   parameter int unsigned CFG_ID        = 1,
   parameter int unsigned CFG_ADDR      = 23,
   parameter int unsigned CFG_DATA      = 24,
   parameter int unsigned CFG_AWIDTH    = 5,
   parameter int unsigned CFG_DWIDTH    = 32,
   parameter int unsigned AXI_LEN_WIDTH = 8,
   parameter int unsigned CONVERT_SHIFT = 0,
   parameter int unsigned OUTST_WIDTH   = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CFG_AWIDTH-1:0]    cfg_addr,
   input  logic [CFG_DWIDTH-1:0]    cfg_data,
   input  logic                     cfg_valid,
   input  logic                     axi_awvalid,
   input  logic                     axi_awready,
   input  logic [AXI_LEN_WIDTH-1:0] axi_awlen,
   input  logic                     axi_bvalid,
   input  logic [1:0]               axi_bresp,
   output logic                     axi_bready,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code
);

   state_t                 r_state, w_state_nxt;
   logic [CFG_DWIDTH-1:0]  r_exp, r_issued, w_issued_nxt, w_exp_nxt, w_len, w_aw_beats;
   logic [OUTST_WIDTH-1:0] r_outst, w_outst_nxt;
   logic                   r_bready, r_busy, r_done, r_err;
   logic [1:0]             r_err_code;
   logic                   w_id_hit, w_len_valid, w_latch;
   logic                   w_aw_inc, w_b_hs, w_b_dec, w_unexp, w_bresp_err, w_sat;
   logic                   w_busy_nxt, w_done_nxt;

   axis_cfg_capture #(
      .CFG_ID     (CFG_ID),
      .CFG_ADDR   (CFG_ADDR),
      .CFG_DATA   (CFG_DATA),
      .CFG_AWIDTH (CFG_AWIDTH),
      .CFG_DWIDTH (CFG_DWIDTH)
   ) u_cfg (
      .clk         (clk),
      .rst         (rst),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_data  (cfg_data),
      .i_cfg_valid (cfg_valid),
      .i_frame_en  (r_state == ST_CONFIG),
      .o_id_hit    (w_id_hit),
      .o_len_valid (w_len_valid),
      .o_len       (w_len)
   );

   assign w_exp_nxt   = w_len >> CONVERT_SHIFT;
   assign w_latch     = (r_state == ST_CONFIG) && w_len_valid;
   assign w_aw_beats  = CFG_DWIDTH'(axi_awlen) + CFG_DWIDTH'(1);
   assign w_aw_inc    = (r_state == ST_ACTIVE) && axi_awvalid && axi_awready;
   assign w_b_hs      = axi_bvalid && r_bready;
   assign w_b_dec     = w_b_hs && (r_outst != '0);
   assign w_unexp     = w_b_hs && (r_outst == '0);
   assign w_bresp_err = w_b_dec && (axi_bresp != BRESP_OKAY);
   assign w_sat       = w_aw_inc && !w_b_hs && (r_outst == '1);
   assign w_issued_nxt = w_aw_inc ? (r_issued + w_aw_beats) : r_issued;

   // An unexpected B never decrements, so outst cannot underflow.
   always_comb begin
      w_outst_nxt = r_outst;
      if (w_aw_inc && !w_b_dec) begin
         if (r_outst != '1) w_outst_nxt = r_outst + OUTST_WIDTH'(1);
      end else if (w_b_dec && !w_aw_inc) begin
         w_outst_nxt = r_outst - OUTST_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_id_hit) w_state_nxt = ST_CONFIG;
         ST_CONFIG: if (w_len_valid) w_state_nxt = (w_exp_nxt == '0) ? ST_DONE : ST_ACTIVE;
         ST_ACTIVE: if ((w_issued_nxt >= r_exp) && (w_outst_nxt == '0)) w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = (w_state_nxt == ST_CONFIG) || (w_state_nxt == ST_ACTIVE);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bready <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_bready <= 1'b1;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp    <= '0;
         r_issued <= '0;
         r_outst  <= '0;
      end else begin
         r_outst <= w_outst_nxt;
         if (w_latch) begin
            r_exp    <= w_exp_nxt;
            r_issued <= '0;
         end else begin
            r_issued <= w_issued_nxt;
         end
      end
   end

   // A new frame clears the flag; an error in the same cycle still wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err      <= 1'b0;
         r_err_code <= '0;
      end else begin
         if (w_latch) begin
            r_err      <= 1'b0;
            r_err_code <= '0;
         end
         if (w_unexp) begin
            r_err <= 1'b1;
            if (!r_err || w_latch) r_err_code <= UNEXP_B;
         end else if (w_bresp_err) begin
            r_err <= 1'b1;
            if (!r_err || w_latch) r_err_code <= axi_bresp;
         end else if (w_sat) begin
            r_err <= 1'b1;
         end
      end
   end

   assign axi_bready = r_bready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign err_code   = r_err_code;

endmodule

// File: tb/tb_axis_write_resp.sv
// Directed bench for axis_write_resp: completion timing, error capture, reset.
module tb_axis_write_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        cfg_valid = 1'b0;
   logic        axi_awvalid = 1'b0;
   logic        axi_awready = 1'b1;
   logic [7:0]  axi_awlen = '0;
   logic        axi_bvalid = 1'b0;
   logic [1:0]  axi_bresp = '0;
   logic        axi_bready, busy, done, err;
   logic [1:0]  err_code;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   axis_write_resp #(
      .CFG_ID        (1),
      .CFG_ADDR      (23),
      .CFG_DATA      (24),
      .CFG_AWIDTH    (5),
      .CFG_DWIDTH    (32),
      .AXI_LEN_WIDTH (8),
      .CONVERT_SHIFT (0),
      .OUTST_WIDTH   (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_valid   (cfg_valid),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_awlen   (axi_awlen),
      .axi_bvalid  (axi_bvalid),
      .axi_bresp   (axi_bresp),
      .axi_bready  (axi_bready),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
      cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   // Leaves the DUT in the cycle where the registered length word is decoded.
   task automatic frame(input logic [31:0] len);
      cfg_wr(5'd23, 32'd1);
      cfg_wr(5'd24, 32'h1000);
      cfg_wr(5'd24, len);
   endtask

   task automatic aw(input logic [7:0] len);
      axi_awvalid = 1'b1; axi_awlen = len;
      tick();
      axi_awvalid = 1'b0;
   endtask

   task automatic b(input logic [1:0] resp);
      axi_bvalid = 1'b1; axi_bresp = resp;
      tick();
      axi_bvalid = 1'b0;
   endtask

   initial begin
      tick();
      chk("rst_bready", axi_bready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      rst = 1'b0;
      chk("rel_bready0", axi_bready, 0);
      tick();
      chk("rel_bready1", axi_bready, 1);

      // 1: 64 words, 4 x 16-beat bursts, all OKAY
      frame(32'd64);
      chk("t1_busy_cfg", busy, 1);
      tick();
      for (int i = 0; i < 4; i++) aw(8'd15);
      for (int i = 0; i < 3; i++) b(2'b00);
      chk("t1_no_early_done", done, 0);
      chk("t1_busy_act", busy, 1);
      b(2'b00);
      chk("t1_done", done, 1);
      chk("t1_busy_off", busy, 0);
      chk("t1_err", err, 0);
      tick();
      chk("t1_done_pulse", done, 0);

      // 2: second B is SLVERR
      frame(32'd64);
      tick();
      for (int i = 0; i < 4; i++) aw(8'd15);
      b(2'b00);
      b(2'b10);
      chk("t2_err_now", err, 1);
      b(2'b00);
      b(2'b00);
      chk("t2_done", done, 1);
      chk("t2_err", err, 1);
      chk("t2_code", err_code, 2);
      tick();

      // 5: zero length clears err and completes straight from CONFIG
      frame(32'd0);
      chk("t5_busy_cfg", busy, 1);
      chk("t5_no_done", done, 0);
      tick();
      chk("t5_done", done, 1);
      chk("t5_busy_off", busy, 0);
      chk("t5_err_clr", err, 0);
      chk("t5_code_clr", err_code, 0);
      tick();
      chk("t5_done_pulse", done, 0);

      // 3: B while idle with nothing outstanding
      b(2'b00);
      chk("t3_err", err, 1);
      chk("t3_code", err_code, 3);
      frame(32'd16);
      tick();
      aw(8'd15);
      b(2'b00);
      chk("t3_outst0_done", done, 1);
      chk("t3_err_clr", err, 0);
      tick();

      // 4: simultaneous AW and B with one burst outstanding
      frame(32'd32);
      tick();
      aw(8'd15);
      axi_awvalid = 1'b1; axi_awlen = 8'd15; axi_bvalid = 1'b1; axi_bresp = 2'b00;
      tick();
      axi_awvalid = 1'b0; axi_bvalid = 1'b0;
      chk("t4_no_done", done, 0);
      chk("t4_busy", busy, 1);
      tick();
      chk("t4_still_wait", done, 0);
      b(2'b00);
      chk("t4_done", done, 1);
      chk("t4_err", err, 0);
      tick();

      // 6: async reset mid-transfer
      frame(32'd64);
      tick();
      aw(8'd15);
      aw(8'd15);
      b(2'b11);
      chk("t6_err_pre", err, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_bready", axi_bready, 0);
      chk("t6_err", err, 0);
      chk("t6_code", err_code, 0);
      chk("t6_done", done, 0);
      tick();
      rst = 1'b0;
      chk("t6_bready_rel", axi_bready, 0);
      tick();
      chk("t6_bready_up", axi_bready, 1);
      b(2'b00);
      chk("t6_unexp_err", err, 1);
      chk("t6_unexp_code", err_code, 3);
      chk("t6_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
